// File: rtl/basic_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : basic_sysid_ext
// Description : Avalon-MM system-ID slave. It holds read-only ID words, a
//               scratch register, an uptime-seconds counter, and a 64-bit
//               free-running cycle counter. The high word of that counter is
//               shadowed so that the pair can be read coherently.
// Revision    : 1.0 - initial release
// ============================================================================
module basic_sysid_ext #(
    parameter logic [15:0] VENDOR_ID   = 16'hEA68,
    parameter logic [15:0] PRODUCT_ID  = 16'h0001,
    parameter logic [31:0] VERSION     = 32'h0000_0000,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    // Value the cycle counter takes while in reset. Keep it at 0 for
    // normal use. A non-zero value lets a simulation reach the 32-bit carry
    // boundary without running 2^32 clocks.
    parameter logic [63:0] CYC_PRELOAD = 64'h0
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_SysID_address,
    input  logic        avs_SysID_read,
    input  logic        avs_SysID_write,
    input  logic [31:0] avs_SysID_writedata,
    input  logic [3:0]  avs_SysID_byteenable,
    output logic [31:0] avs_SysID_readdata,
    output logic        avs_SysID_waitrequest
);

    localparam logic [2:0]  c_addr_id      = 3'd0;
    localparam logic [2:0]  c_addr_version = 3'd1;
    localparam logic [2:0]  c_addr_pat_a   = 3'd2;
    localparam logic [2:0]  c_addr_pat_5   = 3'd3;
    localparam logic [2:0]  c_addr_scratch = 3'd4;
    localparam logic [2:0]  c_addr_uptime  = 3'd5;
    localparam logic [2:0]  c_addr_cyc_lo  = 3'd6;
    localparam logic [2:0]  c_addr_cyc_hi  = 3'd7;
    localparam logic [31:0] c_presc_max    = 32'(CLK_FREQ_HZ - 1);

    logic [31:0] readdata_q, readdata_d;
    logic [31:0] scratch_q,  scratch_d;
    logic [31:0] uptime_q,   uptime_d;
    logic [31:0] presc_q,    presc_d;
    logic [63:0] cyc_q,      cyc_d;
    logic [31:0] shadow_q,   shadow_d;
    logic        rd_done_q,  rd_done_d;
    logic        w_capture;

    // A read is captured on its first cycle. A simultaneous write wins and
    // the read is dropped.
    assign w_capture = avs_SysID_read & ~avs_SysID_write & ~rd_done_q;

    assign avs_SysID_waitrequest = w_capture;
    assign avs_SysID_readdata    = readdata_q;

    // Next-state logic for the counters, scratch, read capture and shadow
    always_comb begin
        cyc_d       = cyc_q + 64'd1;
        scratch_d   = scratch_q;
        readdata_d  = readdata_q;
        shadow_d    = shadow_q;
        rd_done_d   = w_capture;

        if (presc_q == c_presc_max) begin
            presc_d  = '0;
            uptime_d = uptime_q + 32'd1;
        end else begin
            presc_d  = presc_q + 32'd1;
            uptime_d = uptime_q;
        end

        if (avs_SysID_write && avs_SysID_address == c_addr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_SysID_byteenable[b]) begin
                    scratch_d[8*b +: 8] = avs_SysID_writedata[8*b +: 8];
                end
            end
        end

        // Clearing uptime overrides an increment that lands on the same edge
        if (avs_SysID_write && avs_SysID_address == c_addr_uptime) begin
            presc_d  = '0;
            uptime_d = '0;
        end

        if (w_capture) begin
            case (avs_SysID_address)
                c_addr_id:      readdata_d = {VENDOR_ID, PRODUCT_ID};
                c_addr_version: readdata_d = VERSION;
                c_addr_pat_a:   readdata_d = 32'hA5A5_A5A5;
                c_addr_pat_5:   readdata_d = 32'h5A5A_5A5A;
                c_addr_scratch: readdata_d = scratch_q;
                c_addr_uptime:  readdata_d = uptime_q;
                c_addr_cyc_lo: begin
                    readdata_d = cyc_q[31:0];
                    shadow_d   = cyc_q[63:32];
                end
                c_addr_cyc_hi:  readdata_d = shadow_q;
                default:        readdata_d = readdata_q;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            readdata_q <= '0;
            scratch_q  <= '0;
            uptime_q   <= '0;
            presc_q    <= '0;
            cyc_q      <= CYC_PRELOAD;
            shadow_q   <= '0;
            rd_done_q  <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            scratch_q  <= scratch_d;
            uptime_q   <= uptime_d;
            presc_q    <= presc_d;
            cyc_q      <= cyc_d;
            shadow_q   <= shadow_d;
            rd_done_q  <= rd_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_basic_sysid_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_basic_sysid_ext
// Description : Self-checking bench for basic_sysid_ext. It compares the DUT
//               against a behavioural model on every cycle and adds literal
//               checks for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_basic_sysid_ext;

    localparam int unsigned FREQ    = 10;
    localparam logic [63:0] PRELOAD = 64'h0000_0001_FFFF_F000;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        read  = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be    = '0;
    logic [31:0] rdata;
    logic        wreq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    basic_sysid_ext #(
        .VENDOR_ID   (16'hEA68),
        .PRODUCT_ID  (16'h0001),
        .VERSION     (32'h0000_0000),
        .CLK_FREQ_HZ (FREQ),
        .CYC_PRELOAD (PRELOAD)
    ) dut (
        .csi_MCLK_clk          (clk),
        .rsi_MRST_reset        (rst),
        .avs_SysID_address     (addr),
        .avs_SysID_read        (read),
        .avs_SysID_write       (write),
        .avs_SysID_writedata   (wdata),
        .avs_SysID_byteenable  (be),
        .avs_SysID_readdata    (rdata),
        .avs_SysID_waitrequest (wreq)
    );

    // ---------------- behavioural model ----------------
    // Time is counted in clock edges since reset release. The uptime and
    // cycle values are derived arithmetically from that edge count.
    longint unsigned m_edges  = 0;   // edges since reset
    longint unsigned m_clr    = 0;   // edge count at which uptime was last cleared
    logic [31:0]     m_scr    = '0;
    logic [31:0]     m_shadow = '0;
    logic [31:0]     m_rdata  = '0;
    bit              m_done   = 1'b0; // read completes this cycle
    logic [63:0]     t_cyc;
    logic [31:0]     t_upt;

    function automatic logic [63:0] m_cyc();
        return PRELOAD + 64'(m_edges);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges  = 0;
            m_clr    = 0;
            m_scr    = '0;
            m_shadow = '0;
            m_rdata  = '0;
            m_done   = 1'b0;
        end else begin
            t_cyc = m_cyc();
            t_upt = 32'((m_edges - m_clr) / FREQ);
            if (write) begin
                if (addr == 3'd4) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) m_scr[8*b +: 8] = wdata[8*b +: 8];
                end
                if (addr == 3'd5) m_clr = m_edges + 1;
                m_done = 1'b0;
            end else if (read && !m_done) begin
                case (addr)
                    3'd0: m_rdata = 32'hEA68_0001;
                    3'd1: m_rdata = 32'h0000_0000;
                    3'd2: m_rdata = 32'hA5A5_A5A5;
                    3'd3: m_rdata = 32'h5A5A_5A5A;
                    3'd4: m_rdata = m_scr;
                    3'd5: m_rdata = t_upt;
                    3'd6: begin m_rdata = t_cyc[31:0]; m_shadow = t_cyc[63:32]; end
                    default: m_rdata = m_shadow;
                endcase
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
            end
            m_edges = m_edges + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model
    always @(negedge clk) begin
        chk("waitrequest", {31'b0, wreq}, {31'b0, read & ~write & ~m_done});
        chk("readdata", rdata, m_rdata);
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        read = 1'b1;
        #1;
        chk("rd_wait_cycle1", {31'b0, wreq}, 32'd1);
        @(posedge clk); #2;
        chk("rd_wait_cycle2", {31'b0, wreq}, 32'd0);
        d = rdata;
        @(posedge clk); #2;
        read = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        addr  = a;
        wdata = d;
        be    = b;
        write = 1'b1;
        #1;
        chk("wr_wait", {31'b0, wreq}, 32'd0);
        @(posedge clk); #2;
        write = 1'b0;
    endtask

    logic [31:0] d;
    int guard;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_wait", {31'b0, wreq}, 32'd0);
        rst = 1'b0;

        // ID and pattern words
        do_read(3'd0, d); chk("id_word", d, 32'hEA68_0001);
        do_read(3'd1, d); chk("version", d, 32'h0000_0000);
        do_read(3'd2, d); chk("pattern_a5", d, 32'hA5A5_A5A5);
        do_read(3'd3, d); chk("pattern_5a", d, 32'h5A5A_5A5A);

        // Scratch byte enables and read-only protection
        do_write(3'd4, 32'h1122_3344, 4'b1111);
        do_write(3'd4, 32'hAABB_CCDD, 4'b0101);
        do_read(3'd4, d); chk("scratch_be", d, 32'h11BB_33DD);
        do_write(3'd0, 32'hFFFF_FFFF, 4'b1111);
        do_read(3'd0, d); chk("id_ro", d, 32'hEA68_0001);

        // Simultaneous read and write: the write wins
        addr = 3'd4; wdata = 32'hCAFE_F00D; be = 4'b1111; read = 1'b1; write = 1'b1;
        #1;
        chk("rw_wait", {31'b0, wreq}, 32'd0);
        @(posedge clk); #2;
        chk("rw_rdata_held", rdata, 32'hEA68_0001);
        read = 1'b0; write = 1'b0;
        do_read(3'd4, d); chk("rw_scratch", d, 32'hCAFE_F00D);

        // Uptime at 10 clocks per second
        do_write(3'd5, 32'h0, 4'b0000);
        repeat (35) @(posedge clk);
        #2;
        do_read(3'd5, d); chk("uptime_35", d, 32'd3);
        do_write(3'd5, 32'hFFFF_FFFF, 4'b1111);
        repeat (9) @(posedge clk);
        #2;
        do_read(3'd5, d); chk("uptime_9", d, 32'd0);
        do_write(3'd5, 32'h0, 4'b0001);
        repeat (10) @(posedge clk);
        #2;
        do_read(3'd5, d); chk("uptime_10", d, 32'd1);

        // Cycle counter low/high coherence across the 32-bit carry
        guard = 0;
        while (m_cyc() != 64'h0000_0001_FFFF_FFFE && guard < 5000) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("cyc_align_timeout", {31'b0, guard >= 5000}, 32'd0);
        do_read(3'd6, d); chk("cyc_lo_pre", d, 32'hFFFF_FFFE);
        do_read(3'd7, d); chk("cyc_hi_pre", d, 32'h0000_0001);
        do_read(3'd6, d); chk("cyc_lo_post", d, 32'h0000_0002);
        do_read(3'd7, d); chk("cyc_hi_post", d, 32'h0000_0002);

        // Random traffic checked by the model
        for (int i = 0; i < 800; i++) begin
            addr  = 3'($urandom_range(7));
            read  = 1'($urandom_range(1));
            write = ($urandom_range(4) == 0);
            wdata = $urandom;
            be    = 4'($urandom_range(15));
            @(posedge clk); #2;
        end
        read = 1'b0; write = 1'b0;

        // Reset in the middle of a scratch read
        do_write(3'd4, 32'h1234_5678, 4'b1111);
        do_read(3'd4, d); chk("scratch_before_rst", d, 32'h1234_5678);
        addr = 3'd4; read = 1'b1;
        #1;
        chk("rst_read_wait", {31'b0, wreq}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rdata_clear", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_restart_wait1", {31'b0, wreq}, 32'd1);
        @(posedge clk); #2;
        chk("rst_restart_wait2", {31'b0, wreq}, 32'd0);
        chk("rst_scratch_zero", rdata, 32'h0);
        @(posedge clk); #2;
        read = 1'b0;
        do_read(3'd5, d); chk("rst_uptime_zero", d, 32'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
